fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch queue between the program counter / instruction memory and the IF/ID decode stage.
- Each cycle it accepts one {PC, instruction} pair from fetch and buffers up to DEPTH entries.
- It presents the oldest entry to decode with a valid/ready handshake.
- It back-pressures fetch through if_ready, which top level wires to the PC enable. It discards all buffered entries on a branch flush.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- ADDR_W, 2, pointer width, equal to log2(DEPTH).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- if_pc  input  64  PC of the fetched instruction.
- if_instr  input  32  fetched instruction word.
- if_valid  input  1  fetch is presenting a pair this cycle.
- if_ready  output  1  queue can accept; drives the PC enable.
- flush  input  1  taken branch resolved downstream; discard all contents.
- id_valid  output  1  head entry is valid for decode.
- id_ready  input  1  decode consumes the head this cycle.
- id_pc  output  64  PC of head entry.
- id_instr  output  32  instruction of head entry.
- count  output  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular buffer of DEPTH entries, each 96 bits {pc, instr}.
  - wr_ptr and rd_ptr are ADDR_W bits and wrap modulo DEPTH (DEPTH-1 -> 0).
  - count is held in a separate register.
- Push occurs when if_valid && if_ready. The entry is written at wr_ptr, and wr_ptr increments.
- Pop occurs when id_valid && id_ready. rd_ptr increments.
- count_next = count + push - pop. A simultaneous push and pop leaves count unchanged.
- if_ready = (count != DEPTH). It depends only on registered state, with no combinational path from id_ready.
  - When full, push is blocked even if a pop happens in the same cycle. The PC therefore holds for one extra cycle.
- id_valid = (count != 0).
- id_pc / id_instr: head entry when id_valid, otherwise 64'd0 / 32'd0.
- Latency, base build: a pair pushed in cycle N is visible on the id_* outputs in cycle N+1, assuming the queue was empty.
- Ordering: strict FIFO; entries are never reordered or duplicated.
- flush, when asserted without reset:
  - Next cycle: count=0 and rd_ptr=wr_ptr=0.
  - Any push or pop in the flush cycle is discarded.
  - Storage contents are left unchanged (don't-care).
  - if_ready is 1 the cycle after the flush.
- reset (synchronous) takes priority over flush and the handshakes. Next cycle:
  - count=0, pointers=0, all storage entries=0.
  - id_valid=0, id_pc=0, id_instr=0, if_ready=1.
- Reset asserted mid-stream drops all entries. No partial state survives.
- id_pc / id_instr must remain stable while id_valid=1 and id_ready=0.
- if_valid while if_ready=0 is legal. The pair is ignored, and fetch must hold it (PC is not enabled).

Optional Feature:
- Macro FETCH_QUEUE_BYPASS_EN.
- When defined, with count==0, if_valid=1 and no flush:
  - The input pair drives id_pc/id_instr combinationally, and id_valid=1 in the same cycle.
  - If id_ready=1, the pair is consumed directly: no write, pointers and count unchanged.
  - If id_ready=0, the pair is pushed normally.
- Without the macro, the base behaviour applies: one cycle of minimum latency and no combinational path from if_* to id_*.

Test Plan:
- Reset: assert reset 2 cycles with if_valid=1 -> count=0, id_valid=0, id_pc=0, id_instr=0, if_ready=1 after release.
- Streaming: push PCs 0,4,8,12 with instrs 0x91000421.. and id_ready=1 -> id_pc sequence 0,4,8,12 in order, each 1 cycle after push; count never exceeds 1. With bypass: same cycle, count stays 0.
- Fill/full: id_ready=0, push 5 pairs (PC 0..16) -> count=4, if_ready=0 after the 4th push, the 5th pair is not accepted. Then id_ready=1 for one cycle -> id_pc goes 0->4, count=3, and if_ready rises the following cycle.
- Wrap-around: 6 push/pop cycles at count=2 steady -> pointers wrap. Output PC order remains strictly ascending by 4 with no gaps.
- Flush: with count=3 (PCs 0x100,0x104,0x108), assert flush together with a push of 0x10C -> next cycle count=0, id_valid=0. A subsequent push of 0x200 appears as the next id_pc.
- Simultaneous push+pop at count=1 -> count stays 1; id_pc advances to the next older entry.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode bus bundle for fetch_queue (fetch push side, decode pop side, flush and occupancy).
// Handshake: a transfer happens on a posedge where valid && ready; valid-side holds its payload until accepted.
interface fetch_queue_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
);
    logic [63:0]     if_pc;
    logic [31:0]     if_instr;
    logic            if_valid;
    logic            if_ready;
    logic            flush;
    logic            id_valid;
    logic            id_ready;
    logic [63:0]     id_pc;
    logic [31:0]     id_instr;
    logic [ADDR_W:0] count;

    modport master (
        output if_pc, if_instr, if_valid, flush, id_ready,
        input  if_ready, id_valid, id_pc, id_instr, count
    );

    modport slave (
        input  if_pc, if_instr, if_valid, flush, id_ready,
        output if_ready, id_valid, id_pc, id_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr} pairs between fetch and IF/ID decode.
// Optional same-cycle empty-queue bypass when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_queue_if.slave bus
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [95:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              has_head;
    logic              push;
    logic              pop;
    logic [95:0]       head;
`ifdef FETCH_QUEUE_BYPASS_EN
    logic              bypass;
`endif

    always_comb begin
        has_head     = (count_q != '0);
        head         = mem_q[rd_ptr_q];
        // Ready comes only from registered occupancy, so a pop never frees a slot in the same cycle.
        bus.if_ready = (count_q != FULL_CNT);
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass       = !has_head && bus.if_valid && !bus.flush;
        bus.id_valid = has_head || bypass;
        if (has_head) begin
            {bus.id_pc, bus.id_instr} = head;
        end else if (bypass) begin
            {bus.id_pc, bus.id_instr} = {bus.if_pc, bus.if_instr};
        end else begin
            {bus.id_pc, bus.id_instr} = '0;
        end
        // A bypassed pair that decode takes immediately never touches storage.
        push = bus.if_valid && bus.if_ready && !(bypass && bus.id_ready);
`else
        bus.id_valid = has_head;
        {bus.id_pc, bus.id_instr} = has_head ? head : '0;
        push = bus.if_valid && bus.if_ready;
`endif
        pop      = has_head && bus.id_ready;
        wr_ptr_d = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
        count_d  = count_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);
    end

    assign bus.count = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.flush) begin
            // Storage is left as-is; zeroed pointers and count make it unreachable.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {bus.if_pc, bus.if_instr};
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed test-plan steps then random traffic, checked against a queue model.
module tb_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic clk;
  logic reset;

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  logic [95:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  bit last_acc = 1'b0;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive, check mid-cycle against the model, then advance the model
  task automatic step(input bit rst, input bit fl, input bit v, input logic [63:0] pc,
                      input logic [31:0] ins, input bit idr, input bit chk);
    int          sz;
    bit          byp;
    bit          e_rdy;
    bit          e_valid;
    logic [95:0] e_head;
    bit          acc;
    bit          pop;
    reset        = rst;
    bus.flush    = fl;
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_instr = ins;
    bus.id_ready = idr;
    @(negedge clk);
    sz  = exp_q.size();
    byp = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp = (sz == 0) && v && !fl;
`endif
    e_rdy   = (sz != DEPTH);
    e_valid = (sz != 0) || byp;
    if (sz != 0)  e_head = exp_q[0];
    else if (byp) e_head = {pc, ins};
    else          e_head = '0;
    if (chk) begin
      check("if_ready", 96'(bus.if_ready), 96'(e_rdy));
      check("id_valid", 96'(bus.id_valid), 96'(e_valid));
      check("id_pc", 96'(bus.id_pc), 96'(e_head[95:32]));
      check("id_instr", 96'(bus.id_instr), 96'(e_head[31:0]));
      check("count", 96'(bus.count), 96'(sz));
    end
    acc = v && e_rdy && !(byp && idr);
    pop = (sz != 0) && idr;
    @(posedge clk);
    #1;
    if (rst || fl) begin
      exp_q.delete();
      last_acc = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({pc, ins});
      last_acc = acc;
    end
  endtask

  initial begin
    logic [63:0] cur_pc;
    bit          rst;
    bit          fl;
    bit          v;
    bit          idr;
    reset        = 1'b1;
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_pc    = '0;
    bus.if_instr = '0;
    bus.id_ready = 1'b0;
    @(posedge clk);
    #1;

    // reset held two cycles with fetch presenting a pair
    step(1, 0, 1, 64'h40, 32'h1234, 0, 0);
    step(1, 0, 1, 64'h40, 32'h1234, 0, 1);
    step(0, 0, 0, 64'h0, 32'h0, 0, 1);

    // streaming with decode always ready
    for (int i = 0; i < 4; i++) step(0, 0, 1, 64'(i * 4), 32'h91000421 + 32'(i), 1, 1);
    step(0, 0, 0, 64'h0, 32'h0, 1, 1);
    step(0, 0, 0, 64'h0, 32'h0, 1, 1);

    // fill to full, fifth pair refused, one pop, fetch keeps presenting PC 16
    for (int i = 0; i < 5; i++) step(0, 0, 1, 64'(i * 4), 32'ha0000000 + 32'(i), 0, 1);
    step(0, 0, 1, 64'd16, 32'ha0000004, 1, 1);
    step(0, 0, 1, 64'd16, 32'ha0000004, 0, 1);
    step(0, 0, 0, 64'h0, 32'h0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 64'h0, 32'h0, 1, 1);

    // wrap-around at steady occupancy 2
    step(0, 0, 1, 64'h300, 32'hb0, 0, 1);
    step(0, 0, 1, 64'h304, 32'hb1, 0, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 64'h308 + 64'(i * 4), 32'hb2 + 32'(i), 1, 1);
    step(0, 0, 0, 64'h0, 32'h0, 1, 1);
    step(0, 0, 0, 64'h0, 32'h0, 1, 1);
    step(0, 0, 0, 64'h0, 32'h0, 1, 1);

    // flush at count 3 together with a push, then a fresh push
    step(0, 0, 1, 64'h100, 32'hc0, 0, 1);
    step(0, 0, 1, 64'h104, 32'hc1, 0, 1);
    step(0, 0, 1, 64'h108, 32'hc2, 0, 1);
    step(0, 1, 1, 64'h10c, 32'hc3, 1, 1);
    step(0, 0, 1, 64'h200, 32'hd0, 0, 1);
    step(0, 0, 0, 64'h0, 32'h0, 0, 1);

    // simultaneous push+pop at count 1 (0x200 queued)
    step(0, 0, 1, 64'h204, 32'hd1, 1, 1);
    step(0, 0, 0, 64'h0, 32'h0, 0, 1);
    step(0, 0, 0, 64'h0, 32'h0, 1, 1);

    // random traffic; fetch holds its pair until accepted
    cur_pc = 64'h1000;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      fl  = ($urandom_range(0, 24) == 0);
      v   = ($urandom_range(0, 3) != 0);
      idr = (i % 50 < 15) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      step(rst, fl, v, cur_pc, $urandom, idr, 1);
      if (rst || fl) cur_pc = {32'h0, $urandom} & ~64'h3;
      else if (last_acc) cur_pc = cur_pc + 64'd4;
    end
    step(0, 0, 0, 64'h0, 32'h0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
